cell_bcd_converter: RTL and testbench
=====================================

Name: cell_bcd_converter

Overview:
- Sequential binary-to-BCD converter between the 16-cell counter bank (256-bit packed counter vector) and the ASCII text generator.
- On a refresh request it captures a coherent snapshot of all counters.
- Converts each 16-bit cell to 5 BCD digits using shift-add-3 (double dabble), one bit per clock.
- Publishes the digits as a packed vector for character lookup.

Parameters:
- NUM_CELLS, 16, number of counter cells in the packed input.
- CELL_W, 16, bit width of each cell.
- DIGITS, 5, BCD digits per cell; must be >= ceil(CELL_W*log10(2)).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- data_raw  input  NUM_CELLS*CELL_W  packed counters; cell c = data_raw[NUM_CELLS*CELL_W-1-c*CELL_W -: CELL_W] (cell 0 at MSBs).
- start  input  1  conversion request, level-sampled in IDLE.
- bcd_out  output  NUM_CELLS*DIGITS*4  packed BCD; cell c = bcd_out[NUM_CELLS*DIGITS*4-1-c*DIGITS*4 -: DIGITS*4], most significant digit in top nibble.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when all cells are written.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous, active-high.
- Reset values: bcd_out=0, busy=0, done=0, state=IDLE, snapshot=0, cell index=0.
- States: IDLE, LOAD, SHIFT, STORE.
- IDLE:
  - done=0.
  - If start=1 at edge E0: snapshot <= data_raw, cell index <= 0, busy <= 1, go to LOAD.
- LOAD (1 cycle): shift register bin <= snapshot cell[index]; BCD accumulator <= 0; bit counter <= 0; go to SHIFT.
- SHIFT (CELL_W cycles), per cycle:
  - Every accumulator digit >= 5 gets +3.
  - Then {acc,bin} shifts left by 1.
  - After the CELL_W-th shift, go to STORE.
- STORE (1 cycle):
  - bcd_out slot[index] <= acc; other slots hold.
  - If index = NUM_CELLS-1: busy <= 0, done <= 1, go to IDLE.
  - Otherwise index <= index+1, go to LOAD.
- Timing with defaults (start accepted at E0):
  - Per cell: CELL_W+2 = 18 cycles.
  - Slot k updates at edge E(18k+18).
  - busy falls and done rises at E288; done is high exactly one cycle.
  - Next start can be accepted at E289 or later.
- Coherency: data_raw changes after E0 do not affect the current conversion. Output slots reflect only the snapshot taken at E0.
- start while busy=1 (LOAD/SHIFT/STORE): ignored, not queued.
- start held high continuously: back-to-back conversions, one accepted per IDLE visit.
- Unconverted slots keep their previous frame's values until overwritten, so the display never shows partial digits within a cell.
- Width rules: add-3 is performed on 4-bit digits. No overflow detection; parameter constraint guarantees fit. 65535 yields 6,5,5,3,5.
- Reset mid-conversion: same-edge abort to IDLE with all reset values. bcd_out cleared, no done pulse.
- reset and start high on the same edge: reset wins.

Optional Feature:
- Macro: CELL_BCD_LEADING_BLANK_EN.
- When defined: in STORE, each leading zero digit is replaced with 4'hF (blank code for the text generator). The least significant digit is always kept.
  - 42 -> FFF42.
  - 0 -> FFFF0.
- When undefined: leading zeros are stored as 0.
- Timing is identical in both builds.

Test Plan:
1. Reset, data_raw all zero, pulse start -> busy=1 from E0; done pulse at E288 only; bcd_out=0.
2. Cell0=65535, cell15=1, others 0, start -> slot0=20'h65535 at E18; slot15=20'h00001 at E288; others 20'h00000.
3. Cells 0..15 = 0..15, start -> slot10=20'h00010, slot15=20'h00015; exactly one done pulse, at E288.
4. Start accepted with cell3=100; at E50 set cell3=999 and pulse start -> slot3=20'h00100; no second conversion begins before E289.
5. Reset asserted at E100 mid-conversion -> next cycle busy=0, done=0, bcd_out=0; a new start then completes normally in 288 cycles.
6. With CELL_BCD_LEADING_BLANK_EN: cell0=42, cell1=0, cell2=10000 -> slots 20'hFFF42, 20'hFFFF0, 20'h10000.

Source files
------------

// File: rtl/cell_bcd_converter.sv
// rtl/cell_bcd_converter.sv - sequential binary-to-BCD converter for the counter cell bank
// Optional build macro: CELL_BCD_LEADING_BLANK_EN (leading zero digits stored as 4'hF)
module cell_bcd_converter #(
   parameter int NUM_CELLS = 16,
   parameter int CELL_W    = 16,
   parameter int DIGITS    = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_CELLS*CELL_W-1:0]     data_raw,
   input  logic                            start,
   output logic [NUM_CELLS*DIGITS*4-1:0]   bcd_out,
   output logic                            busy,
   output logic                            done
);

   localparam int SLOT_W = DIGITS * 4;
   localparam int BCD_W  = NUM_CELLS * SLOT_W;
   localparam int IN_W   = NUM_CELLS * CELL_W;
   localparam int IDX_W  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam int CNT_W  = $clog2(CELL_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE
   } state_t;

   state_t             state;
   logic [IN_W-1:0]    snapshot;
   logic [IDX_W-1:0]   cell_idx;
   logic [CELL_W-1:0]  bin;
   logic [SLOT_W-1:0]  acc;
   logic [CNT_W-1:0]   bit_cnt;

   logic [CELL_W-1:0]  sel_cell;
   logic [SLOT_W-1:0]  acc_adj;
   logic [SLOT_W-1:0]  store_val;

   // Pick the snapshot cell addressed by the current cell index (cell 0 sits at the MSBs)
   always_comb begin
      sel_cell = '0;
      for (int c = 0; c < NUM_CELLS; c++) begin
         if (cell_idx == IDX_W'(c)) begin
            sel_cell = snapshot[IN_W-1-c*CELL_W -: CELL_W];
         end
      end
   end

   // Add-3 correction on every accumulator digit that is 5 or more, ahead of the shift
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[d*4 +: 4] >= 4'd5) begin
            acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
         end
      end
   end

   // Value written to the output slot; optionally blanks leading zeros but never the last digit
   always_comb begin
      store_val = acc;
`ifdef CELL_BCD_LEADING_BLANK_EN
      begin : blank_leading
         logic leading;
         leading = 1'b1;
         for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && (acc[d*4 +: 4] == 4'd0)) begin
               store_val[d*4 +: 4] = 4'hF;
            end else begin
               leading = 1'b0;
            end
         end
      end
`endif
   end

   // Conversion FSM: snapshot, per-cell load, CELL_W shift-add-3 steps, then slot store
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         snapshot <= '0;
         cell_idx <= '0;
         bin      <= '0;
         acc      <= '0;
         bit_cnt  <= '0;
         bcd_out  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  snapshot <= data_raw;
                  cell_idx <= '0;
                  busy     <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               bin     <= sel_cell;
               acc     <= '0;
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               {acc, bin} <= {acc_adj[SLOT_W-2:0], bin, 1'b0};
               bit_cnt    <= bit_cnt + 1'b1;
               if (bit_cnt == CNT_W'(CELL_W - 1)) begin
                  state <= S_STORE;
               end
            end
            S_STORE: begin
               for (int c = 0; c < NUM_CELLS; c++) begin
                  if (cell_idx == IDX_W'(c)) begin
                     bcd_out[BCD_W-1-c*SLOT_W -: SLOT_W] <= store_val;
                  end
               end
               if (cell_idx == IDX_W'(NUM_CELLS - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  cell_idx <= cell_idx + 1'b1;
                  state    <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_bcd_converter.sv
// tb/tb_cell_bcd_converter.sv - self-checking bench for cell_bcd_converter
module tb_cell_bcd_converter;

   localparam int NUM_CELLS = 16;
   localparam int CELL_W    = 16;
   localparam int DIGITS    = 5;
   localparam int SLOT_W    = DIGITS * 4;
   localparam int BCD_W     = NUM_CELLS * SLOT_W;
   localparam int IN_W      = NUM_CELLS * CELL_W;
   localparam int FRAME     = NUM_CELLS * (CELL_W + 2);

   typedef struct {
      int                slot;
      logic [SLOT_W-1:0] val;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [IN_W-1:0]   data_raw;
   logic              start;
   logic [BCD_W-1:0]  bcd_out;
   logic              busy;
   logic              done;

   int                checks   = 0;
   int                failures = 0;
   exp_t              sb[$];
   logic [SLOT_W-1:0] prev[NUM_CELLS];

   cell_bcd_converter #(
      .NUM_CELLS (NUM_CELLS),
      .CELL_W    (CELL_W),
      .DIGITS    (DIGITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data_raw (data_raw),
      .start    (start),
      .bcd_out  (bcd_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [SLOT_W-1:0] model_bcd(input int v);
      logic [SLOT_W-1:0] r;
      int                x;
      bit                leading;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef CELL_BCD_LEADING_BLANK_EN
      leading = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (leading && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
         else leading = 1'b0;
      end
`else
      leading = 1'b0;
`endif
      return r;
   endfunction

   function automatic logic [SLOT_W-1:0] get_slot(input int k);
      logic [BCD_W-1:0] t;
      t = bcd_out >> ((NUM_CELLS - 1 - k) * SLOT_W);
      return t[SLOT_W-1:0];
   endfunction

   function automatic int get_cell(input int c);
      logic [IN_W-1:0] t;
      t = data_raw >> ((NUM_CELLS - 1 - c) * CELL_W);
      return int'(t[CELL_W-1:0]);
   endfunction

   task automatic set_cell(input int c, input int v);
      data_raw[IN_W-1-c*CELL_W -: CELL_W] = CELL_W'(v);
   endtask

   // Drive start across one edge (E0) and queue the expected slots of this frame
   task automatic accept(input string tag);
      exp_t e;
      start = 1'b1;
      for (int c = 0; c < NUM_CELLS; c++) begin
         e.slot = c;
         e.val  = model_bcd(get_cell(c));
         sb.push_back(e);
      end
      tick();
      start = 1'b0;
      check({tag, "_busy_e0"}, 64'(busy), 64'd1);
   endtask

   // Walk one frame edge by edge: done/busy every cycle, slot k at E(18k+18)
   task automatic run_frame(input string tag, input int inject_at, input int reset_at);
      exp_t e;
      for (int n = 1; n <= FRAME; n++) begin
         if (n == inject_at) begin
            set_cell(3, 999);
            start = 1'b1;
         end
         if (n == reset_at) reset = 1'b1;
         tick();
         if (n == reset_at) begin
            check({tag, "_rst_busy"}, 64'(busy), 64'd0);
            check({tag, "_rst_done"}, 64'(done), 64'd0);
            check({tag, "_rst_bcd_hi"}, 64'(bcd_out[BCD_W-1 -: 64]), 64'd0);
            check({tag, "_rst_bcd_or"}, 64'(|bcd_out), 64'd0);
            reset = 1'b0;
            sb.delete();
            for (int c = 0; c < NUM_CELLS; c++) prev[c] = '0;
            return;
         end
         check({tag, "_done"}, 64'(done), 64'(n == FRAME));
         check({tag, "_busy"}, 64'(busy), 64'(n < FRAME));
         if (n % (CELL_W + 2) == 0) begin
            int k;
            k = n / (CELL_W + 2) - 1;
            if (sb.size() == 0) begin
               check({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
               e = sb.pop_front();
               check($sformatf("%s_slot%0d_idx", tag, k), 64'(e.slot), 64'(k));
               check($sformatf("%s_slot%0d", tag, k), 64'(get_slot(e.slot)), 64'(e.val));
               prev[e.slot] = e.val;
            end
            if (k < NUM_CELLS - 1) begin
               check($sformatf("%s_hold%0d", tag, k + 1), 64'(get_slot(k + 1)), 64'(prev[k + 1]));
            end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      data_raw = '0;
      for (int c = 0; c < NUM_CELLS; c++) prev[c] = '0;
      tick();
      tick();
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_bcd", 64'(|bcd_out), 64'd0);
      reset = 1'b0;
      tick();

      // 1: all zeros
      accept("t1");
      run_frame("t1", -1, -1);
      tick();
      check("t1_done_low", 64'(done), 64'd0);

      // 2: max value and boundary cell
      data_raw = '0;
      set_cell(0, 65535);
      set_cell(15, 1);
      accept("t2");
      run_frame("t2", -1, -1);
      tick();

      // 3: ramp 0..15
      for (int c = 0; c < NUM_CELLS; c++) set_cell(c, c);
      accept("t3");
      run_frame("t3", -1, -1);
      tick();

      // 4: coherency, start while busy, start held into the next IDLE
      data_raw = '0;
      set_cell(3, 100);
      accept("t4a");
      run_frame("t4a", 50, -1);
      accept("t4b");
      run_frame("t4b", -1, -1);
      tick();

      // 5: reset mid-conversion, then reset winning over start, then a clean frame
      for (int c = 0; c < NUM_CELLS; c++) set_cell(c, 1000 + c * 37);
      accept("t5a");
      run_frame("t5a", -1, 100);
      start = 1'b1;
      reset = 1'b1;
      tick();
      check("t5_rst_vs_start", 64'(busy), 64'd0);
      start = 1'b0;
      reset = 1'b0;
      tick();
      accept("t5b");
      run_frame("t5b", -1, -1);
      tick();

      // 6: leading-zero cases (blanked only in the blanking build)
      data_raw = '0;
      set_cell(0, 42);
      set_cell(1, 0);
      set_cell(2, 10000);
      set_cell(4, 9);
      accept("t6");
      run_frame("t6", -1, -1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
